// File: rtl/rs_enc_par4.sv
// rs_enc_par4: byte-serial systematic Reed-Solomon encoder over GF(2^8), 4 parity symbols.
// Generator g(x) = (x+1)(x+a)(x+a^2)(x+a^3), field poly 0x11D, a = 0x02.
// Message bytes pass straight through, followed by parity p3, p2, p1, p0.
// Ports:
//   i_clk        clock, all state on rising edge
//   i_res        asynchronous active-high reset
//   i_valid      input byte valid
//   i_data       input message byte
//   o_in_ready   encoder accepts i_data this cycle
//   o_valid      output byte valid
//   o_data       codeword byte (message, then parity)
//   o_last       last parity byte of a codeword
//   o_is_par     o_data is a parity byte
//   i_out_ready  downstream accepts o_data
module rs_enc_par4 #(
   parameter int unsigned DATA_LEN = 28
) (
   input  logic       i_clk,
   input  logic       i_res,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_in_ready,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_last,
   output logic       o_is_par,
   input  logic       i_out_ready
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_PAR  = CNT_W'(3);

   localparam logic [7:0] G3 = 8'h0F;
   localparam logic [7:0] G2 = 8'h36;
   localparam logic [7:0] G1 = 8'h78;
   localparam logic [7:0] G0 = 8'h40;

   typedef enum logic {ST_DATA = 1'b0, ST_PAR = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       p0_q, p1_q, p2_q, p3_q;
   logic [7:0]       p0_d, p1_d, p2_d, p3_d;
   logic [7:0]       o_data_d;
   logic             o_valid_d, o_last_d, o_is_par_d;
   logic             out_free, in_xfer, par_load;
   logic [7:0]       fb;

   // Multiply by a constant; unrolls into a fixed XOR network.
   function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] k);
      logic [7:0] acc;
      logic [7:0] a;
      acc = '0;
      a   = x;
      for (int i = 0; i < 8; i++) begin
         if (k[i]) acc = acc ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
      end
      return acc;
   endfunction

   // Output register is single-entry: it can take a new byte when empty or draining.
   assign out_free   = !o_valid || i_out_ready;
   assign o_in_ready = !i_res && (state_q == ST_DATA) && out_free;
   assign in_xfer    = i_valid && o_in_ready;
   assign par_load   = (state_q == ST_PAR) && out_free;
   assign fb         = i_data ^ p3_q;

   // State register
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) state_q <= ST_DATA;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_DATA: if (in_xfer && (cnt_q == LAST_DATA)) state_d = ST_PAR;
         ST_PAR:  if (par_load && (cnt_q == LAST_PAR)) state_d = ST_DATA;
         default: state_d = ST_DATA;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      p0_d       = p0_q;
      p1_d       = p1_q;
      p2_d       = p2_q;
      p3_d       = p3_q;
      cnt_d      = cnt_q;
      o_data_d   = o_data;
      o_valid_d  = o_valid;
      o_last_d   = o_last;
      o_is_par_d = o_is_par;
      case (state_q)
         ST_DATA: begin
            if (in_xfer) begin
               p3_d       = p2_q ^ gf_mul_const(fb, G3);
               p2_d       = p1_q ^ gf_mul_const(fb, G2);
               p1_d       = p0_q ^ gf_mul_const(fb, G1);
               p0_d       = gf_mul_const(fb, G0);
               o_data_d   = i_data;
               o_valid_d  = 1'b1;
               o_is_par_d = 1'b0;
               o_last_d   = 1'b0;
               cnt_d      = (cnt_q == LAST_DATA) ? '0 : CNT_W'(cnt_q + 1'b1);
            end else if (o_valid && i_out_ready) begin
               o_valid_d = 1'b0;
               o_last_d  = 1'b0;
            end
         end
         ST_PAR: begin
            // Parity drains highest degree first; zero fill leaves p-regs clean.
            if (par_load) begin
               o_data_d   = p3_q;
               p3_d       = p2_q;
               p2_d       = p1_q;
               p1_d       = p0_q;
               p0_d       = '0;
               o_valid_d  = 1'b1;
               o_is_par_d = 1'b1;
               o_last_d   = (cnt_q == LAST_PAR);
               cnt_d      = (cnt_q == LAST_PAR) ? '0 : CNT_W'(cnt_q + 1'b1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         p0_q     <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         p3_q     <= '0;
         cnt_q    <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
         o_last   <= 1'b0;
         o_is_par <= 1'b0;
      end else begin
         p0_q     <= p0_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         p3_q     <= p3_d;
         cnt_q    <= cnt_d;
         o_data   <= o_data_d;
         o_valid  <= o_valid_d;
         o_last   <= o_last_d;
         o_is_par <= o_is_par_d;
      end
   end

endmodule

// File: tb/tb_rs_enc_par4.sv
// tb_rs_enc_par4: self-checking bench for rs_enc_par4 against a polynomial-division
// reference model; a second instance with DATA_LEN=1 covers the shortest codeword.
module tb_rs_enc_par4;

   localparam int unsigned DLEN = 28;
   localparam int unsigned N    = DLEN + 4;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst;
   logic       valid, in_ready, ovalid, olast, opar, oready;
   logic [7:0] data, odata;
   logic       v1, ir1, ov1, ol1, op1, or1;
   logic [7:0] d1, od1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit stall_mode = 1'b0;

   logic [9:0] obs_q[$];
   int         cyc_q[$];

   always #5 clk = ~clk;

   rs_enc_par4 #(.DATA_LEN(DLEN)) u_dut (
      .i_clk(clk), .i_res(rst), .i_valid(valid), .i_data(data),
      .o_in_ready(in_ready), .o_valid(ovalid), .o_data(odata),
      .o_last(olast), .o_is_par(opar), .i_out_ready(oready)
   );

   rs_enc_par4 #(.DATA_LEN(1)) u_dut1 (
      .i_clk(clk), .i_res(rst), .i_valid(v1), .i_data(d1),
      .o_in_ready(ir1), .o_valid(ov1), .o_data(od1),
      .o_last(ol1), .o_is_par(op1), .i_out_ready(or1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = '0;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) r = r ^ x;
         y = y >> 1;
         x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      end
      return r;
   endfunction

   // Systematic codeword: message followed by remainder of m(x)*x^4 / g(x).
   function automatic bq_t encode(input bq_t m);
      logic [7:0] g[5] = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
      bq_t r;
      bq_t cw;
      logic [7:0] coef;
      r = m;
      for (int i = 0; i < 4; i++) r.push_back(8'h00);
      for (int i = 0; i < m.size(); i++) begin
         coef = r[i];
         for (int j = 1; j < 5; j++) r[i+j] = r[i+j] ^ gmul(coef, g[j]);
      end
      cw = m;
      for (int i = 0; i < 4; i++) cw.push_back(r[m.size()+i]);
      return cw;
   endfunction

   // Evaluate codeword polynomial at a^j (first byte = highest degree).
   function automatic logic [7:0] synd(input bq_t c, input int j);
      logic [7:0] root = 8'h01;
      logic [7:0] s = 8'h00;
      for (int i = 0; i < j; i++) root = gmul(root, 8'h02);
      for (int i = 0; i < c.size(); i++) s = gmul(s, root) ^ c[i];
      return s;
   endfunction

   function automatic bq_t rand_msg();
      bq_t m;
      for (int i = 0; i < DLEN; i++) m.push_back(8'($urandom));
      return m;
   endfunction

   // Output monitor: records every transfer and checks stability while stalled.
   initial begin : monitor
      logic       stalled;
      logic [10:0] held;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled)
               check("stall_hold", 32'({ovalid, olast, opar, odata}), 32'(held));
            if (ovalid && oready) begin
               obs_q.push_back({olast, opar, odata});
               cyc_q.push_back(cyc);
            end
            stalled = ovalid && !oready;
            held    = {ovalid, olast, opar, odata};
         end
      end
   end

   // Downstream ready: always on, or ~50% random when stalling.
   initial begin : ready_drv
      oready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         oready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input bq_t m);
      int i = 0;
      int budget = 0;
      while (i < m.size()) begin
         @(posedge clk);
         #1;
         valid = 1'b1;
         data  = m[i];
         @(negedge clk);
         if (in_ready) i++;
         budget++;
         if (budget > 5000) begin
            check("send_timeout", 32'(i), 32'(m.size()));
            break;
         end
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int b = 0;
      while (obs_q.size() < n && b < 5000) begin
         @(negedge clk);
         b++;
      end
      check("drain_timeout", 32'(obs_q.size() >= n), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic compare_cw(input string tag, input bq_t cw, input int base);
      for (int i = 0; i < N; i++)
         check(tag, 32'(obs_q[base+i]), 32'({(i == N-1), (i >= DLEN), cw[i]}));
   endtask

   function automatic bq_t obs_bytes(input int base);
      bq_t c;
      for (int i = 0; i < N; i++) c.push_back(obs_q[base+i][7:0]);
      return c;
   endfunction

   initial begin : main
      bq_t m, cw, all_m;
      bq_t msgs[3];
      logic [7:0] e1[5] = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};

      rst   = 1'b1;
      valid = 1'b1;
      data  = 8'hA5;
      v1    = 1'b1;
      d1    = 8'h5A;
      or1   = 1'b1;

      // Reset held with valid input
      repeat (3) @(negedge clk);
      check("rst_ovalid",   32'(ovalid),   32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_odata",    32'(odata),    32'd0);
      check("rst_flags",    32'({olast, opar}), 32'd0);
      check("rst1_state",   32'({ov1, ir1, od1}), 32'd0);

      @(posedge clk);
      #1;
      rst   = 1'b0;
      valid = 1'b0;
      v1    = 1'b0;
      @(negedge clk);
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // DATA_LEN=1 instance, single byte 0x01
      @(posedge clk);
      #1;
      v1 = 1'b1;
      d1 = 8'h01;
      @(negedge clk);
      check("len1_in_ready", 32'(ir1), 32'd1);
      @(posedge clk);
      #1;
      v1 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("len1_byte", 32'({ov1, ol1, op1, od1}), 32'({1'b1, (k == 4), (k > 0), e1[k]}));
      end
      @(negedge clk);
      check("len1_idle", 32'(ov1), 32'd0);

      // All-zero message
      obs_q.delete();
      cyc_q.delete();
      m.delete();
      for (int i = 0; i < DLEN; i++) m.push_back(8'h00);
      send(m);
      wait_bytes(N);
      compare_cw("zero_cw", encode(m), 0);

      // Message 1..28: parity vs model, syndromes must vanish
      obs_q.delete();
      cyc_q.delete();
      m.delete();
      for (int i = 1; i <= DLEN; i++) m.push_back(8'(i));
      send(m);
      wait_bytes(N);
      compare_cw("seq_cw", encode(m), 0);
      cw = obs_bytes(0);
      for (int j = 0; j < 4; j++) check("seq_synd", 32'(synd(cw, j)), 32'd0);

      // Back-to-back random codewords, no stall, full throughput
      all_m.delete();
      for (int c = 0; c < 3; c++) begin
         msgs[c] = rand_msg();
         for (int i = 0; i < DLEN; i++) all_m.push_back(msgs[c][i]);
      end
      obs_q.delete();
      cyc_q.delete();
      send(all_m);
      wait_bytes(3 * N);
      for (int c = 0; c < 3; c++) compare_cw("b2b_cw", encode(msgs[c]), c * N);
      for (int c = 0; c < 3; c++) begin
         cw = obs_bytes(c * N);
         check("b2b_synd0", 32'(synd(cw, 0)), 32'd0);
         check("b2b_synd3", 32'(synd(cw, 3)), 32'd0);
      end
      check("b2b_rate", 32'(cyc_q[3*N-1] - cyc_q[0]), 32'(3*N - 1));

      // Same stream with random backpressure
      obs_q.delete();
      cyc_q.delete();
      stall_mode = 1'b1;
      send(all_m);
      wait_bytes(3 * N);
      stall_mode = 1'b0;
      for (int c = 0; c < 3; c++) compare_cw("stall_cw", encode(msgs[c]), c * N);
      check("stall_count", 32'(obs_q.size()), 32'(3 * N));

      // Reset after byte 10 of a codeword
      repeat (3) @(posedge clk);
      #1;
      obs_q.delete();
      m = rand_msg();
      while (m.size() > 10) void'(m.pop_back());
      send(m);
      rst = 1'b1;
      #1;
      check("mid_rst_ovalid", 32'(ovalid), 32'd0);
      check("mid_rst_odata",  32'(odata),  32'd0);
      check("mid_rst_flags",  32'({olast, opar, in_ready}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      cyc_q.delete();
      m = rand_msg();
      send(m);
      wait_bytes(N);
      compare_cw("post_rst_cw", encode(m), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
